// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - round-robin shared 4-operand adder with one-entry response slot
// Grants one requester per cycle into a registered x+y+z+w+cin result slot.
module adder_share_arb #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int CNTW = 16,
    localparam int IDW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*4*W-1:0]   req_ops,
    input  logic [N-1:0]       req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W+1:0]       rsp_sum,
    output logic               rsp_zero,
    output logic [IDW-1:0]     rsp_id,
    output logic               busy,
    output logic [CNTW-1:0]    ops_done
);

    logic            rsp_valid_q, rsp_valid_d;
    logic [W+1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] ops_done_q, ops_done_d;

    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW:0]    cand;
    logic            can_accept;
    logic            grant;
    logic [4*W-1:0]  win_ops;
    logic [W+1:0]    win_sum;

    // Rotating priority scan starting at ptr_q; the extra bit keeps the wrap exact for non-power-of-two N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N)) begin
                cand = cand - (IDW+1)'(N);
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_ops = req_ops[int'(win)*4*W +: 4*W];
        win_sum = (W+2)'(win_ops[W-1:0])
                + (W+2)'(win_ops[2*W-1:W])
                + (W+2)'(win_ops[3*W-1:2*W])
                + (W+2)'(win_ops[4*W-1:3*W])
                + (W+2)'(req_cin[win]);
    end

    assign can_accept = !rsp_valid_q || rsp_ready;
    assign grant      = found && can_accept && !rst;

    always_comb begin
        req_ready   = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        ops_done_d  = ops_done_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            if (ops_done_q != '1) begin
                ops_done_d = ops_done_q + CNTW'(1);
            end
        end

        // A grant in the same cycle as a drain overwrites the slot, so it stays full.
        if (grant) begin
            req_ready[win] = 1'b1;
            rsp_valid_d    = 1'b1;
            rsp_sum_d      = win_sum;
            rsp_zero_d     = (win_sum == '0);
            rsp_id_d       = win;
            ptr_d          = (win == IDW'(N-1)) ? '0 : win + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
            ops_done_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_id    = rsp_id_q;
    assign ops_done  = ops_done_q;
    assign busy      = rsp_valid_q || (|req_valid);

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one registered 4-operand adder (sum of x+y+z+w+cin) among N requesters.
- Round-robin arbitration, valid/ready request channels, one-entry registered response slot carrying sum, zero flag and requester id.
- Sits between the stream sources of the datapath and the single adder resource; the adder is instantiated inside this block.

Parameters:
- W, 8, operand width in bits.
- N, 4, number of requesters (2..16).
- IDW, $clog2(N), requester-id width (derived, not overridden).
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N  bit i: requester i presents an operation.
- req_ready  output  N  bit i: requester i's operation accepted this cycle.
- req_ops  input  N*4*W  requester i occupies bits [(i+1)*4*W-1 : i*4*W]; within it x=[W-1:0], y=[2W-1:W], z=[3W-1:2W], w=[4W-1:3W].
- req_cin  input  N  carry-in per requester.
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer takes result.
- rsp_sum  output  W+2  x+y+z+w+cin.
- rsp_zero  output  1  rsp_sum == 0.
- rsp_id  output  IDW  index of requester that produced result.
- busy  output  1  rsp_valid or any req_valid.
- ops_done  output  CNTW  count of completed response handshakes, saturating.

Behaviour:
- Reset (rst=1 at clk edge): rsp_valid=0, rsp_sum=0, rsp_zero=0, rsp_id=0, rr pointer=0, ops_done=0. An in-flight or pending response is discarded; no req_ready during reset cycle.
- Slot state: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready (slot free or draining this cycle).
- Arbitration (combinational, each cycle): the winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod N. req_ready is one-hot on the winner iff can_accept, else all zero. req_ready never depends on the winner's own data.
- Accept (req_valid[w] & req_ready[w]):
  - Next edge: rsp_valid=1, rsp_sum=sum(w), rsp_zero=(sum==0), rsp_id=w.
  - ptr <= (w+1) mod N.
  - Latency exactly 1 cycle.
- No accept, rsp_valid & rsp_ready: slot goes EMPTY; ptr unchanged.
- Simultaneous drain and accept: the slot is overwritten with the new result and stays FULL. This gives 1 op/cycle throughput with rsp_ready held high.
- Stall: while rsp_valid & !rsp_ready, rsp_sum, rsp_zero and rsp_id are held stable, and no grants are issued.
- Arithmetic:
  - Operands are zero-extended to W+2 bits.
  - Maximum value is 4*(2^W-1)+1 < 2^(W+2), so overflow is impossible.
- ops_done increments on each rsp_valid & rsp_ready and saturates at 2^CNTW-1 (no wrap).
- Requesters may deassert req_valid without a handshake; the arbiter treats this as a withdrawn request and takes no other action.
- Fairness: with all N valid continuously and rsp_ready=1, grants rotate 0,1,..,N-1,0; each requester waits at most N-1 grants.

Test Plan:
- Reset then single op: req_valid=0001, x=1,y=2,z=3,w=4,cin=1 → req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_sum=11, rsp_zero=0, rsp_id=0; ops_done=1 after rsp_ready.
- Max operands: x=y=z=w=255, cin=1 → rsp_sum=1021 (10'h3FD). All zeros, cin=0 → rsp_sum=0, rsp_zero=1.
- Round-robin: req_valid=1111 held, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3,0 one cycle later.
- Backpressure: slot FULL with id=2 sum=40, rsp_ready=0 for 5 cycles, req_valid=1011 → req_ready=0000 and outputs stable. On rsp_ready=1, the same cycle grants requester 3 (ptr=3), and the slot reloads next cycle.
- Skip and wrap: ptr=3, req_valid=0110 → grant 1, ptr becomes 2. Next request 0001 only → grant 0.
- Reset mid-operation: slot FULL and req_valid=1111; assert rst 1 cycle → rsp_valid=0, ptr=0, ops_done=0. The first grant after release goes to requester 0.
- Counter saturation (CNTW=4): 17 completed handshakes → ops_done=15.
